// File: rtl/au_add_csv_acc.sv
// au_add_csv_acc: multi-operand accumulator that folds each operand into a
// redundant sum/carry pair via a 3:2 carry-save step, then resolves the
// frame total with a single carry-propagate add before presenting it.
module au_add_csv_acc #(
    parameter int WIDTH   = 8,
    parameter int MAX_OPS = 16,
    localparam int OW     = WIDTH + $clog2(MAX_OPS),
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OW-1:0]    out_sum,
    output logic [CW-1:0]    out_cnt,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [1:0] ACC = 2'd0;
    localparam logic [1:0] RES = 2'd1;
    localparam logic [1:0] OUT = 2'd2;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);

    logic [1:0]    state_q, state_d;
    logic [OW-1:0] s_q, s_d;
    logic [OW-1:0] c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [OW-1:0] sum_q, sum_d;
    logic [CW-1:0] ocnt_q, ocnt_d;
    logic          oovf_q, oovf_d;

    logic [OW-1:0] xExt;
    logic [OW-1:0] majVec;
    logic          accept;

    // Handshake outputs: the input side is held off while reset is asserted
    // and whenever the result path owns the frame.
    assign in_ready  = rst_n && (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_sum   = sum_q;
    assign out_cnt   = ocnt_q;
    assign out_ovf   = oovf_q;

    assign xExt   = {{(OW - WIDTH){1'b0}}, in_data};
    assign majVec = (s_q & c_q) | (s_q & xExt) | (c_q & xExt);
    assign accept = in_valid && in_ready && !clr;

    // Next-state logic: carry-save fold in ACC, carry-propagate resolve in
    // RES, hold in OUT; clr overrides everything and restarts the frame.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;

        if (clr) begin
            state_d = ACC;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        s_d = s_q ^ c_q ^ xExt;
                        c_d = majVec << 1;
                        if (cnt_q == MAX_CNT) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (in_last) begin
                            state_d = RES;
                        end
                    end
                end
                RES: begin
                    sum_d   = s_q + c_q;
                    ocnt_d  = cnt_q;
                    oovf_d  = ovf_q;
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any frame and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_au_add_csv_acc.sv
// Testbench for au_add_csv_acc with WIDTH=8, MAX_OPS=16 (12-bit sum, 5-bit count).
`timescale 1ns/1ps
module tb_au_add_csv_acc;

    localparam int WIDTH   = 8;
    localparam int MAX_OPS = 16;
    localparam int OW      = 12;
    localparam int CW      = 5;

    logic             clk;
    logic             rst_n;
    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OW-1:0]    out_sum;
    logic [CW-1:0]    out_cnt;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    int checkCount;
    int errorCount;
    int ops[$];

    au_add_csv_acc #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents the operands in ops[0..n-1]; optional random in_valid gaps with
    // junk data/last on idle cycles. Returns one cycle after the final accept.
    task automatic applyStimulus(input int n, input bit gaps, input bit markLast);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = in_valid ? WIDTH'(ops[i]) : WIDTH'($urandom_range(0, 255));
            in_last  = in_valid ? (markLast && i == n - 1) : 1'($urandom_range(0, 1));
            if (in_valid && in_ready) i++;
            nextCycle();
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (guard >= 2000) checkOutput("send_timeout", 0, 1);
    endtask

    // Waits for the result (optionally with random out_ready gaps), checks it
    // at the handshake cycle, then completes the handshake.
    task automatic getResult(input string tag, input logic [31:0] expSum,
                             input logic [31:0] expCnt, input logic [31:0] expOvf,
                             input bit gaps);
        int guard;
        bit done;
        guard = 0;
        done = 0;
        while (!done && guard < 200) begin
            out_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && out_ready) begin
                checkOutput({tag, "_sum"}, 32'(out_sum), expSum);
                checkOutput({tag, "_cnt"}, 32'(out_cnt), expCnt);
                checkOutput({tag, "_ovf"}, 32'(out_ovf), expOvf);
                done = 1;
            end
            nextCycle();
            guard++;
        end
        out_ready = 1'b0;
        if (!done) checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    task automatic fill(input int n, input int value);
        ops.delete();
        for (int i = 0; i < n; i++) ops.push_back(value);
    endtask

    initial begin
        int zeros;
        int n;
        int refSum;
        logic [OW-1:0] heldSum;
        logic [CW-1:0] heldCnt;
        logic heldOvf;

        checkCount = 0;
        errorCount = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_sum", 32'(out_sum), 0);
        checkOutput("rst_out_cnt", 32'(out_cnt), 0);
        checkOutput("rst_out_ovf", 32'(out_ovf), 0);
        #3 rst_n = 1'b1;
        nextCycle();
        checkOutput("post_rst_in_ready", 32'(in_ready), 1);

        // Single operand with latency checks
        ops.delete();
        ops.push_back('hA5);
        applyStimulus(1, 0, 1);
        checkOutput("a5_res_valid", 32'(out_valid), 0);
        checkOutput("a5_res_ready", 32'(in_ready), 0);
        nextCycle();
        checkOutput("a5_out_valid", 32'(out_valid), 1);
        getResult("a5", 'h0A5, 1, 0, 0);

        // Four 8'hFF back-to-back, out_ready held high
        out_ready = 1'b1;
        fill(4, 'hFF);
        applyStimulus(4, 0, 1);
        zeros = 0;
        heldSum = '0;
        heldCnt = '0;
        while (!in_ready && zeros < 10) begin
            if (out_valid) begin
                heldSum = out_sum;
                heldCnt = out_cnt;
            end
            zeros++;
            nextCycle();
        end
        out_ready = 1'b0;
        checkOutput("ff4_sum", 32'(heldSum), 'h3FC);
        checkOutput("ff4_cnt", 32'(heldCnt), 4);
        checkOutput("ff4_busy_cycles", zeros, 2);

        // Overflow: 17 x 8'hFF
        fill(17, 'hFF);
        applyStimulus(17, 0, 1);
        getResult("ovf", 'h0EF, 16, 1, 0);

        // Backpressure: out_ready low 5 cycles in OUT while in_valid stays high
        fill(2, 'h11);
        applyStimulus(2, 0, 1);
        in_valid = 1'b1;
        in_data  = 'h55;
        in_last  = 1'b1;
        nextCycle();
        checkOutput("bp_valid", 32'(out_valid), 1);
        heldSum = out_sum;
        heldCnt = out_cnt;
        heldOvf = out_ovf;
        checkOutput("bp_first_sum", 32'(heldSum), 'h022);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", 32'(in_ready), 0);
            checkOutput("bp_sum_stable", 32'(out_sum), 32'(heldSum));
            checkOutput("bp_cnt_stable", 32'(out_cnt), 32'(heldCnt));
            checkOutput("bp_ovf_stable", 32'(out_ovf), 32'(heldOvf));
            checkOutput("bp_valid_held", 32'(out_valid), 1);
            nextCycle();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        getResult("bp", 'h022, 2, 0, 0);
        ops.delete();
        ops.push_back('h01);
        ops.push_back('h02);
        applyStimulus(2, 0, 1);
        getResult("bp_next", 'h003, 2, 0, 0);

        // clr after three operands, coincident with a valid operand
        fill(3, 'h20);
        applyStimulus(3, 0, 0);
        in_valid = 1'b1;
        in_data  = 'h10;
        in_last  = 1'b1;
        clr      = 1'b1;
        nextCycle();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("clr_out_valid", 32'(out_valid), 0);
        checkOutput("clr_in_ready", 32'(in_ready), 1);
        ops.delete();
        ops.push_back('h07);
        applyStimulus(1, 0, 1);
        getResult("clr_next", 'h007, 1, 0, 0);

        // clr while a result is pending drops out_valid
        fill(2, 'h03);
        applyStimulus(2, 0, 1);
        nextCycle();
        checkOutput("clr_out_pending", 32'(out_valid), 1);
        clr = 1'b1;
        nextCycle();
        clr = 1'b0;
        checkOutput("clr_out_dropped", 32'(out_valid), 0);

        // Asynchronous reset in ACC mid-frame
        fill(2, 'h40);
        applyStimulus(2, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_acc_in_ready", 32'(in_ready), 0);
        checkOutput("arst_acc_out_valid", 32'(out_valid), 0);
        checkOutput("arst_acc_out_sum", 32'(out_sum), 0);
        #2 rst_n = 1'b1;
        nextCycle();
        ops.delete();
        ops.push_back('h30);
        ops.push_back('h05);
        applyStimulus(2, 0, 1);
        getResult("arst_acc_next", 'h035, 2, 0, 0);

        // Asynchronous reset in OUT
        fill(3, 'h80);
        applyStimulus(3, 0, 1);
        nextCycle();
        checkOutput("arst_out_pre_valid", 32'(out_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 0);
        checkOutput("arst_out_sum", 32'(out_sum), 0);
        checkOutput("arst_out_cnt", 32'(out_cnt), 0);
        #2 rst_n = 1'b1;
        nextCycle();
        ops.delete();
        ops.push_back('h0C);
        applyStimulus(1, 0, 1);
        getResult("arst_out_next", 'h00C, 1, 0, 0);

        // Random frames with gaps on both sides, against a reference model
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(1, 20);
            ops.delete();
            refSum = 0;
            for (int i = 0; i < n; i++) begin
                ops.push_back($urandom_range(0, 255));
                refSum += ops[i];
            end
            applyStimulus(n, 1, 1);
            getResult("rand", refSum % 4096, (n > MAX_OPS) ? MAX_OPS : n,
                      (n > MAX_OPS) ? 1 : 0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/au_add_csv_acc.md
# au_add_csv_acc

Sequential multi-operand accumulator built around the three-operand carry-save adder. Each accepted operand is folded into a redundant sum/carry register pair in one cycle with no carry propagation. After the last operand of a frame, a single carry-propagate addition resolves the result. It sits between an operand stream source and a result consumer, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: operand word length (>= 1).
- MAX_OPS, 16: operands per frame without overflow (>= 2).
- Derived: OW = WIDTH + clog2(MAX_OPS) is the result width; CW = clog2(MAX_OPS+1) is the count width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort; discards the frame in progress and any pending result.
- in_data  in  WIDTH  unsigned operand.
- in_valid  in  1  operand valid.
- in_last  in  1  marks the final operand of a frame; qualified by in_valid.
- in_ready  out  1  operand accepted on an edge where in_valid & in_ready.
- out_sum  out  OW  frame sum, modulo 2^OW.
- out_cnt  out  CW  operands in the frame, saturating at MAX_OPS.
- out_ovf  out  1  frame contained more than MAX_OPS operands.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed on an edge where out_valid & out_ready.

## Operation
- States: ACC, RES, OUT. Reset and clr both enter ACC.
- Redundant registers: S[OW-1:0] and C[OW-1:0]. C holds carries already weighted, i.e. pre-shifted. Both are 0 in ACC at frame start.
- ACC:
  - in_ready = 1.
  - On accept, with x = zero-extended in_data: S <= S ^ C ^ x; C <= (maj(S,C,x) << 1) truncated to OW bits.
  - cnt increments and saturates at MAX_OPS.
  - ovf is set if an operand is accepted while cnt == MAX_OPS.
  - in_last on an accept moves the state to RES.
- RES:
  - in_ready = 0.
  - out_sum <= S + C, modulo 2^OW.
  - out_cnt <= cnt; out_ovf <= ovf.
  - Clear S, C, cnt and ovf; move to OUT.
- OUT:
  - out_valid = 1 and in_ready = 0.
  - out_sum, out_cnt and out_ovf are held stable until the handshake.
  - On out_valid & out_ready, move to ACC.
- clr (any state):
  - Next state is ACC; S, C, cnt and ovf are cleared; out_valid drops at that edge.
  - An operand presented in the same cycle is discarded, even though in_ready = 1.
  - clr has priority over every other event.
- Arithmetic is unsigned. The modulo-2^OW result is exact when ovf = 0.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset values: in_ready = 0 during reset, then 1 from the first cycle after deassertion (state ACC). out_valid = 0, out_sum = 0, out_cnt = 0, out_ovf = 0.
- Reset mid-frame or mid-output: all state is lost immediately; no result is produced.
- Accept rate: one operand per cycle in ACC with no bubbles.
- Latency: last operand accepted at edge k gives state RES during cycle k+1. out_valid is high after edge k+1.
- Minimum frame period: frame length + 2 cycles, when out_ready is held at 1.
- out_ready high on the first OUT cycle: the handshake occurs at edge k+2, and in_ready returns to 1 after that edge.
- out_ready may be asserted before out_valid; it has no effect outside OUT.
- out_valid may not drop without a handshake, except on clr or reset.
- Single-operand frame: in_last on the first accept is legal. The result is the operand itself, with cnt = 1.

## Test plan
- Single operand, WIDTH=8: in_data=8'hA5 with in_last -> out_sum=12'h0A5, out_cnt=1, out_ovf=0; out_valid one cycle after the RES cycle.
- Back-to-back four operands 8'hFF, no gaps, last on the fourth -> out_sum=12'h3FC, out_cnt=4. in_ready is 0 for exactly two cycles when out_ready=1.
- Overflow: 17 operands of 8'hFF -> out_sum=(17*255) mod 4096=12'h0EF, out_cnt=16, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT with in_valid=1 throughout.
  - out_sum, out_cnt and out_ovf stay stable; in_ready=0; no operand is accepted.
  - After the handshake, the next frame of 8'h01 and 8'h02 -> 12'h003.
- clr after 3 operands, with clr coincident with a valid operand 8'h10 -> that operand is dropped. The next frame 8'h07 with last -> 12'h007, out_cnt=1.
- Random gaps on in_valid and out_ready, 1000 frames of random length 1..20, checked against a reference sum mod 4096 and against the ovf rule.
- Asynchronous reset asserted in ACC and again in OUT -> outputs go to reset values immediately, and the next frame is correct.
